// File: rtl/v_rams_dp_wb.sv
// rtl/v_rams_dp_wb.sv - single-clock true dual-port RAM with byte enables, ack pipeline and collision counter
// Port A wins on bytes written by both ports in the same cycle; memory itself is never reset.
module v_rams_dp_wb #(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0,
  parameter int CW       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stba,
  input  logic              stbb,
  input  logic              wea,
  input  logic              web,
  input  logic [DW/8-1:0]   sela,
  input  logic [DW/8-1:0]   selb,
  input  logic [AW-1:0]     addra,
  input  logic [AW-1:0]     addrb,
  input  logic [DW-1:0]     dia,
  input  logic [DW-1:0]     dib,
  output logic [DW-1:0]     doa,
  output logic [DW-1:0]     dob,
  output logic              acka,
  output logic              ackb,
  output logic              coll,
  output logic [CW-1:0]     coll_cnt,
  input  logic              coll_clr
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  logic          wr_a, wr_b, same, hit;
  logic [DW-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;
  logic          va1, vb1;
  logic [DW-1:0] da1, db1;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] base,
                                          input logic [NB-1:0] sel,
                                          input logic [DW-1:0] d);
    logic [DW-1:0] w;
    w = base;
    for (int b = 0; b < NB; b++)
      if (sel[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  assign wr_a = stba & wea;
  assign wr_b = stbb & web;
  assign same = (addra == addrb);
  // A write with no byte selected still counts as a write here.
  assign hit  = stba & stbb & same & (wea | web);

  // B is merged before A so A's bytes win where both ports select them.
  always_comb begin
    old_a = mem[addra];
    old_b = mem[addrb];
    new_a = old_a;
    if (wr_b && same) new_a = merge(new_a, selb, dib);
    if (wr_a)         new_a = merge(new_a, sela, dia);
    new_b = old_b;
    if (wr_b)         new_b = merge(new_b, selb, dib);
    if (wr_a && same) new_b = merge(new_b, sela, dia);
    rd_a = (RDW_MODE != 0) ? new_a : old_a;
    rd_b = (RDW_MODE != 0) ? new_b : old_b;
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_a) mem[addra] <= new_a;
    if (rst_n && wr_b) mem[addrb] <= new_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va1      <= 1'b0;
      vb1      <= 1'b0;
      da1      <= '0;
      db1      <= '0;
      coll     <= 1'b0;
      coll_cnt <= '0;
    end else begin
      va1  <= stba;
      vb1  <= stbb;
      if (stba) da1 <= rd_a;
      if (stbb) db1 <= rd_b;
      coll <= hit;
      if (coll_clr)
        coll_cnt <= '0;
      else if (hit && (coll_cnt != {CW{1'b1}}))
        coll_cnt <= coll_cnt + CW'(1);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic          va2, vb2;
      logic [DW-1:0] da2, db2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          va2 <= 1'b0;
          vb2 <= 1'b0;
          da2 <= '0;
          db2 <= '0;
        end else begin
          va2 <= va1;
          vb2 <= vb1;
          if (va1) da2 <= da1;
          if (vb1) db2 <= db1;
        end
      end
      assign acka = va2;
      assign ackb = vb2;
      assign doa  = da2;
      assign dob  = db2;
    end else begin : g_noreg
      assign acka = va1;
      assign ackb = vb1;
      assign doa  = da1;
      assign dob  = db1;
    end
  endgenerate

endmodule
